fir4_a: RTL and testbench
=========================

FIR4_A -- requirements
Module: fir4_a

Interface
- REQ-001: Parameter DATA_W, default 8, SHALL set the signed sample width of x_in.
- REQ-002: Parameter COEF_W, default 8, SHALL set the signed coefficient width of h0..h3.
- REQ-003: Parameter OUT_W, default 16, SHALL set the signed output width of y_out.
- REQ-004: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-005: rst  input  1  SHALL be the reset, synchronous and active-low.
- REQ-006: x_in  input  DATA_W  SHALL be the signed input sample, sampled every rising edge.
- REQ-007: h0, h1, h2, h3  input  COEF_W each  SHALL be the signed tap coefficients, applied to x[n], x[n-1], x[n-2], x[n-3] respectively.
- REQ-008: y_out  output  OUT_W  SHALL be the signed registered filter output.

Function
- REQ-009: The block SHALL hold a 3-deep signed delay line d1, d2, d3; on each rising edge, with rst high, it SHALL update d1<=x_in, d2<=d1, d3<=d2.
- REQ-010: On each rising edge, with rst high, y_out SHALL load h0*x_in + h1*d1 + h2*d2 + h3*d3, using pre-edge delay-line values.
- REQ-011: Latency SHALL be one cycle: a sample presented before edge k SHALL first contribute to y_out after edge k.
- REQ-012: All multiplies SHALL be signed, full precision (DATA_W+COEF_W bits).
- REQ-013: The sum SHALL be formed in a full-precision accumulator of DATA_W+COEF_W+2 bits, so no intermediate overflow occurs.
- REQ-014: Without saturation, y_out SHALL be the low OUT_W bits of the accumulator (two's-complement wrap).
- REQ-015: Coefficients SHALL be used combinationally at each edge with no internal storage; a coefficient change SHALL affect the next y_out only.
- REQ-016: There SHALL be no valid/ready handshake; every edge is a new sample.

Reset
- REQ-017: When rst is low at a rising edge, d1, d2, d3 and y_out SHALL all become 0, regardless of x_in and coefficients.
- REQ-018: Reset asserted mid-stream SHALL discard all history; the first edge after release SHALL yield y_out = h0*x_in.
- REQ-019: rst SHALL have no asynchronous effect; outputs change only on clk edges.

Configuration
- REQ-020: With macro FIR4_SAT_EN defined, y_out SHALL saturate instead of wrapping: accumulator > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1, and accumulator < -2^(OUT_W-1) gives -2^(OUT_W-1).
- REQ-021: With FIR4_SAT_EN undefined, the wrap behaviour of REQ-014 SHALL apply, and no saturation logic SHALL be present.

Structure
- REQ-022: A shared package fir4_pkg SHALL hold the default widths, the tap count constant (4) and the accumulator width derivation.
- REQ-023: A sub-module fir4_tap SHALL implement one signed coefficient-by-sample multiply.
- REQ-024: fir4_a SHALL instantiate fir4_tap four times and contain the delay line, adder tree, optional saturator and output register.

Verification
- REQ-025: Reset: rst=0 for 2 cycles with x_in=9 and h=1,2,3,4 -> y_out=0; after release with x_in=9, y_out=9.
- REQ-026: Ramp: h=1,2,3,4; x_in=5,6,7,8,0,0,0,0 on successive cycles -> y_out=5,16,34,60,61,52,32,0.
- REQ-027: Signs: h0=-1, other taps 0, x_in=-128 -> y_out=128; h0=-1, x_in=5 -> y_out=-5.
- REQ-028: Overflow: all h=127 and x_in=127 held 4+ cycles -> y_out=-1020 without FIR4_SAT_EN, 32767 with it; all h=-128 and x_in=-128 held -> 0 without the macro, 32767 with it.
- REQ-029: Mid-stream reset: run the ramp of REQ-026, pull rst low after the 3rd sample -> y_out=0 next edge; release with x_in=1 and h=1,2,3,4 -> y_out=1, then 2 with x_in=0.
- REQ-030: Coefficient change: x_in=1 held for 4+ cycles with h=1,2,3,4 -> y_out=10; then set h3=0 -> the next y_out is 6.

Source files
------------

// File: rtl/fir4_pkg.sv
// rtl/fir4_pkg.sv - shared widths, tap count and accumulator sizing for the 4-tap FIR
package fir4_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_OUT_W  = 16;
  localparam int NUM_TAPS   = 4;

  // Two guard bits cover the growth of summing four full-precision products.
  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 2;
  endfunction

endpackage

// File: rtl/fir4_tap.sv
// rtl/fir4_tap.sv - one signed coefficient-by-sample multiply at full precision
module fir4_tap #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic signed [DATA_W-1:0]        x,
  input  logic signed [COEF_W-1:0]        h,
  output logic signed [DATA_W+COEF_W-1:0] p
);

  logic signed [DATA_W+COEF_W-1:0] x_ext;
  logic signed [DATA_W+COEF_W-1:0] h_ext;

  // Operands widened to the product width so the multiply is exact in that width.
  assign x_ext = $signed({{COEF_W{x[DATA_W-1]}}, x});
  assign h_ext = $signed({{DATA_W{h[COEF_W-1]}}, h});
  assign p     = x_ext * h_ext;

endmodule

// File: rtl/fir4_a.sv
// rtl/fir4_a.sv - 4-tap direct-form FIR with registered output; FIR4_SAT_EN selects saturation over wrap
module fir4_a
  import fir4_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [COEF_W-1:0] h0,
  input  logic signed [COEF_W-1:0] h1,
  input  logic signed [COEF_W-1:0] h2,
  input  logic signed [COEF_W-1:0] h3,
  output logic signed [OUT_W-1:0]  y_out
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W);

  logic signed [DATA_W-1:0] d1, d2, d3;
  logic signed [DATA_W-1:0] tap_x [NUM_TAPS];
  logic signed [COEF_W-1:0] tap_h [NUM_TAPS];
  logic signed [PROD_W-1:0] prod  [NUM_TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  y_next;

  assign tap_x[0] = x_in;
  assign tap_x[1] = d1;
  assign tap_x[2] = d2;
  assign tap_x[3] = d3;
  assign tap_h[0] = h0;
  assign tap_h[1] = h1;
  assign tap_h[2] = h2;
  assign tap_h[3] = h3;

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    fir4_tap #(
      .DATA_W(DATA_W),
      .COEF_W(COEF_W)
    ) u_tap (
      .x(tap_x[i]),
      .h(tap_h[i]),
      .p(prod[i])
    );
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      acc = acc + ACC_W'(prod[i]);
    end
  end

`ifdef FIR4_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] ACC_MIN = $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});
  localparam logic signed [OUT_W-1:0] OUT_MAX = $signed({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [OUT_W-1:0] OUT_MIN = $signed({1'b1, {(OUT_W-1){1'b0}}});

  always_comb begin
    y_next = OUT_W'(acc);
    if (acc > ACC_MAX) begin
      y_next = OUT_MAX;
    end else if (acc < ACC_MIN) begin
      y_next = OUT_MIN;
    end
  end
`else
  // Two's-complement wrap: keep only the low output bits of the accumulator.
  always_comb begin
    y_next = OUT_W'(acc);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      d1    <= '0;
      d2    <= '0;
      d3    <= '0;
      y_out <= '0;
    end else begin
      d1    <= x_in;
      d2    <= d1;
      d3    <= d2;
      y_out <= y_next;
    end
  end

endmodule

// File: tb/tb_fir4_a.sv
// tb/tb_fir4_a.sv - self-checking bench for fir4_a: vector table, corner sequences, random vs model
module tb_fir4_a;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [7:0] x_in = '0;
  logic signed [7:0] h0 = '0, h1 = '0, h2 = '0, h3 = '0;
  logic signed [15:0] y_out;

  int checks = 0;
  int failures = 0;

  fir4_a dut (
    .clk  (clk),
    .rst  (rst),
    .x_in (x_in),
    .h0   (h0),
    .h1   (h1),
    .h2   (h2),
    .h3   (h3),
    .y_out(y_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic signed [7:0] x;
    logic signed [7:0] h [4];
    logic signed [15:0] y;
    string             name;
  } vec_t;

  vec_t vecs[$];

`ifdef FIR4_SAT_EN
  localparam int OVP3 = 32767;
  localparam int OVP4 = 32767;
  localparam int OVN2 = 32767;
  localparam int OVN3 = 32767;
  localparam int OVN4 = 32767;
`else
  localparam int OVP3 = -17149;
  localparam int OVP4 = -1020;
  localparam int OVN2 = -32768;
  localparam int OVN3 = -16384;
  localparam int OVN4 = 0;
`endif

  task automatic add(input int r, input int x, input int a, input int b,
                     input int c, input int d, input int y, input string n);
    vec_t v;
    v.rst  = r[0];
    v.x    = 8'(x);
    v.h[0] = 8'(a);
    v.h[1] = 8'(b);
    v.h[2] = 8'(c);
    v.h[3] = 8'(d);
    v.y    = 16'(y);
    v.name = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic signed [15:0] act, input logic signed [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: y_out=%0d expected %0d", n, act, exp);
    end
  endtask

  task automatic drive(input int r, input int x, input int a, input int b, input int c, input int d);
    rst  = r[0];
    x_in = 8'(x);
    h0   = 8'(a);
    h1   = 8'(b);
    h2   = 8'(c);
    h3   = 8'(d);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: output is the sum over the last four samples times their taps,
  // with history wiped by reset; then wrapped or clamped to 16 bits.
  int hist[4];

  function automatic logic signed [15:0] fold(input int acc);
`ifdef FIR4_SAT_EN
    if (acc > 32767) return 16'sd32767;
    if (acc < -32768) return -16'sd32768;
    return 16'(acc);
`else
    return 16'(acc);
`endif
  endfunction

  initial begin
    logic signed [15:0] exp_y;
    int acc;
    int hv[4];

    add(0, 9, 1, 2, 3, 4, 0, "reset_c1");
    add(0, 9, 1, 2, 3, 4, 0, "reset_c2");
    add(1, 9, 1, 2, 3, 4, 9, "reset_release");
    add(0, 0, 1, 2, 3, 4, 0, "pre_ramp");
    add(1, 5, 1, 2, 3, 4, 5, "ramp0");
    add(1, 6, 1, 2, 3, 4, 16, "ramp1");
    add(1, 7, 1, 2, 3, 4, 34, "ramp2");
    add(1, 8, 1, 2, 3, 4, 60, "ramp3");
    add(1, 0, 1, 2, 3, 4, 61, "ramp4");
    add(1, 0, 1, 2, 3, 4, 52, "ramp5");
    add(1, 0, 1, 2, 3, 4, 32, "ramp6");
    add(1, 0, 1, 2, 3, 4, 0, "ramp7");
    add(1, -128, -1, 0, 0, 0, 128, "sign_negneg");
    add(1, 5, -1, 0, 0, 0, -5, "sign_negpos");
    add(0, 0, 0, 0, 0, 0, 0, "pre_ovp");
    add(1, 127, 127, 127, 127, 127, 16129, "ovp1");
    add(1, 127, 127, 127, 127, 127, 32258, "ovp2");
    add(1, 127, 127, 127, 127, 127, OVP3, "ovp3");
    add(1, 127, 127, 127, 127, 127, OVP4, "ovp4");
    add(1, 127, 127, 127, 127, 127, OVP4, "ovp5");
    add(0, 0, 0, 0, 0, 0, 0, "pre_ovn");
    add(1, -128, -128, -128, -128, -128, 16384, "ovn1");
    add(1, -128, -128, -128, -128, -128, OVN2, "ovn2");
    add(1, -128, -128, -128, -128, -128, OVN3, "ovn3");
    add(1, -128, -128, -128, -128, -128, OVN4, "ovn4");
    add(1, -128, -128, -128, -128, -128, OVN4, "ovn5");
    add(0, 0, 1, 2, 3, 4, 0, "pre_coef");
    add(1, 1, 1, 2, 3, 4, 1, "coef1");
    add(1, 1, 1, 2, 3, 4, 3, "coef2");
    add(1, 1, 1, 2, 3, 4, 6, "coef3");
    add(1, 1, 1, 2, 3, 4, 10, "coef4");
    add(1, 1, 1, 2, 3, 4, 10, "coef5");
    add(1, 1, 1, 2, 3, 0, 6, "coef_h3_zero");

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst  = vecs[i].rst;
      x_in = vecs[i].x;
      h0   = vecs[i].h[0];
      h1   = vecs[i].h[1];
      h2   = vecs[i].h[2];
      h3   = vecs[i].h[3];
      tick();
      check(vecs[i].name, y_out, vecs[i].y);
    end

    // Mid-stream reset, including a check that rst alone does not move y_out.
    drive(0, 0, 1, 2, 3, 4); tick();
    drive(1, 5, 1, 2, 3, 4); tick(); check("mid_s0", y_out, 16'sd5);
    drive(1, 6, 1, 2, 3, 4); tick(); check("mid_s1", y_out, 16'sd16);
    drive(1, 7, 1, 2, 3, 4); tick(); check("mid_s2", y_out, 16'sd34);
    drive(0, 8, 1, 2, 3, 4); #3;     check("rst_no_async", y_out, 16'sd34);
    tick();                          check("mid_rst", y_out, 16'sd0);
    drive(1, 1, 1, 2, 3, 4); tick(); check("mid_rel1", y_out, 16'sd1);
    drive(1, 0, 1, 2, 3, 4); tick(); check("mid_rel2", y_out, 16'sd2);

    // Random stream against the reference model.
    drive(0, 0, 0, 0, 0, 0); tick();
    for (int k = 0; k < 4; k++) hist[k] = 0;
    hv[0] = 0; hv[1] = 0; hv[2] = 0; hv[3] = 0;
    for (int n = 0; n < 400; n++) begin
      int r;
      int xv;
      r  = ($urandom_range(0, 19) == 0) ? 0 : 1;
      xv = int'($signed(8'($urandom)));
      if ($urandom_range(0, 7) == 0 || n == 0) begin
        for (int k = 0; k < 4; k++) hv[k] = int'($signed(8'($urandom)));
      end
      if ($urandom_range(0, 15) == 0) begin
        xv = ($urandom_range(0, 1) == 0) ? 127 : -128;
        for (int k = 0; k < 4; k++) hv[k] = xv;
      end
      drive(r, xv, hv[0], hv[1], hv[2], hv[3]);
      if (r == 0) begin
        for (int k = 0; k < 4; k++) hist[k] = 0;
        exp_y = 16'sd0;
      end else begin
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = xv;
        acc = 0;
        for (int k = 0; k < 4; k++) acc += hv[k] * hist[k];
        exp_y = fold(acc);
      end
      tick();
      check($sformatf("rand%0d", n), y_out, exp_y);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
